// File: rtl/compute_clock_gate_ctrl.sv
// compute_clock_gate_ctrl
// ---------------------------------------------------------------------------
// Runs in the control-clock domain and drives the active-low compute-clock
// enable for the clock distribution stage. After the MMCM reports lock, a
// host start pulse runs the compute clock for a budget of cycles (0 means
// unlimited). Stall requesters can freeze the compute clock through a
// req/ack handshake, and the block counts compute cycles issued in a run.
//
// Ports:
//   clock              control clock, all logic on the rising edge
//   reset              synchronous, active-high reset
//   locked             MMCM lock (asynchronous, synchronised here)
//   start / stop       single-cycle pulses: begin / abort a run
//   budget             compute cycles per run, sampled on an accepted start
//   stall_req          per-requester freeze request (level)
//   stall_ack          per-requester freeze grant (registered)
//   compute_clock_en_n 0 lets the compute clock toggle
//   running            state is RUN, GATE_WAIT or STALLED
//   done               one-cycle pulse when a run ends by budget or stop
//   lock_lost          sticky: lock dropped outside LOCK_WAIT
//   cycle_count        compute cycles issued in the current/last run
//   stall_cycles       gated cycles of the current/last run
//
// Optional feature macro: CLOCK_GATE_STATS_EN
//   defined   -> stall_cycles counts cycles spent in GATE_WAIT or STALLED
//   undefined -> stall_cycles is tied to 0, no counter is built
// ---------------------------------------------------------------------------
module compute_clock_gate_ctrl #(
    parameter int NUM_REQ      = 4,
    parameter int GATE_LATENCY = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int COUNT_W      = 48
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    input  logic               start,
    input  logic               stop,
    input  logic [COUNT_W-1:0] budget,
    input  logic [NUM_REQ-1:0] stall_req,
    output logic [NUM_REQ-1:0] stall_ack,
    output logic               compute_clock_en_n,
    output logic               running,
    output logic               done,
    output logic               lock_lost,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [COUNT_W-1:0] stall_cycles
);

    localparam int GATE_CNT_W = (GATE_LATENCY > 0) ? $clog2(GATE_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        LOCK_WAIT,
        IDLE,
        RUN,
        GATE_WAIT,
        STALLED
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  locked_sync_q, locked_sync_d;
    logic                    en_n_q, en_n_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    running_q, running_d;
    logic                    done_q, done_d;
    logic                    lock_lost_q, lock_lost_d;
    logic [COUNT_W-1:0]      cycle_count_q, cycle_count_d;
    logic [COUNT_W-1:0]      budget_q, budget_d;
    logic [GATE_CNT_W-1:0]   gate_cnt_q, gate_cnt_d;

    logic locked_s;
    logic start_accept;
    logic budget_hit;

    assign locked_s     = locked_sync_q[SYNC_STAGES-1];
    assign start_accept = (state_q == IDLE) && locked_s && start;
    // The cycle under test is itself counted, so the run ends when it would
    // make the count equal the budget.
    assign budget_hit   = (budget_q != '0) && !en_n_q &&
                          ((cycle_count_q + COUNT_W'(1)) == budget_q);

    always_comb begin
        locked_sync_d[0] = locked;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            locked_sync_d[i] = locked_sync_q[i-1];
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        en_n_d      = en_n_q;
        ack_d       = ack_q;
        done_d      = 1'b0;
        lock_lost_d = lock_lost_q;
        budget_d    = budget_q;
        gate_cnt_d  = gate_cnt_q;

        case (state_q)
            LOCK_WAIT: begin
                en_n_d = 1'b1;
                ack_d  = '0;
                if (locked_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                en_n_d = 1'b1;
                ack_d  = '0;
                if (!locked_s) begin
                    state_d     = LOCK_WAIT;
                    lock_lost_d = 1'b1;
                end else if (start) begin
                    budget_d = budget;
                    en_n_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            default: begin
                // Active states share the top of the priority ladder:
                // lock loss, then stop, then per-state events.
                if (!locked_s) begin
                    state_d     = LOCK_WAIT;
                    en_n_d      = 1'b1;
                    ack_d       = '0;
                    lock_lost_d = 1'b1;
                end else if (stop) begin
                    state_d = IDLE;
                    en_n_d  = 1'b1;
                    ack_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    case (state_q)
                        RUN: begin
                            if (budget_hit) begin
                                state_d = IDLE;
                                en_n_d  = 1'b1;
                                done_d  = 1'b1;
                            end else if (|stall_req) begin
                                state_d    = GATE_WAIT;
                                en_n_d     = 1'b1;
                                gate_cnt_d = GATE_CNT_W'(GATE_LATENCY);
                            end
                        end
                        GATE_WAIT: begin
                            // Leave on the edge where the counter would hit 0,
                            // so STALLED begins GATE_LATENCY cycles after en_n rose.
                            if (gate_cnt_q <= GATE_CNT_W'(1)) begin
                                state_d    = STALLED;
                                gate_cnt_d = '0;
                            end else begin
                                gate_cnt_d = gate_cnt_q - GATE_CNT_W'(1);
                            end
                        end
                        STALLED: begin
                            if (stall_req == '0) begin
                                state_d = RUN;
                                en_n_d  = 1'b0;
                                ack_d   = '0;
                            end else begin
                                ack_d = stall_req;
                            end
                        end
                        default: begin
                            state_d = LOCK_WAIT;
                            en_n_d  = 1'b1;
                            ack_d   = '0;
                        end
                    endcase
                end
            end
        endcase

        running_d = (state_d == RUN) || (state_d == GATE_WAIT) || (state_d == STALLED);
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_accept) begin
            cycle_count_d = '0;
        end else if (!en_n_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + COUNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= LOCK_WAIT;
            locked_sync_q <= '0;
            en_n_q        <= 1'b1;
            ack_q         <= '0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            lock_lost_q   <= 1'b0;
            cycle_count_q <= '0;
            budget_q      <= '0;
            gate_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            locked_sync_q <= locked_sync_d;
            en_n_q        <= en_n_d;
            ack_q         <= ack_d;
            running_q     <= running_d;
            done_q        <= done_d;
            lock_lost_q   <= lock_lost_d;
            cycle_count_q <= cycle_count_d;
            budget_q      <= budget_d;
            gate_cnt_q    <= gate_cnt_d;
        end
    end

`ifdef CLOCK_GATE_STATS_EN
    logic [COUNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (start_accept) begin
            stall_cycles_d = '0;
        end else if (((state_q == GATE_WAIT) || (state_q == STALLED)) &&
                     (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

    assign stall_ack          = ack_q;
    assign compute_clock_en_n = en_n_q;
    assign running            = running_q;
    assign done               = done_q;
    assign lock_lost          = lock_lost_q;
    assign cycle_count        = cycle_count_q;

endmodule

// File: tb/tb_compute_clock_gate_ctrl.sv
// tb_compute_clock_gate_ctrl
// Directed stimulus for compute_clock_gate_ctrl. The stimulus process drives
// inputs on the falling edge and queues the hand-computed output snapshot
// expected right after the next rising edge; a separate monitor samples the
// outputs 1 time unit after each rising edge and compares against the queue.
module tb_compute_clock_gate_ctrl;

    localparam int NUM_REQ      = 4;
    localparam int GATE_LATENCY = 2;
    localparam int SYNC_STAGES  = 2;
    localparam int COUNT_W      = 48;
    localparam logic [COUNT_W-1:0] MAXC = '1;

    logic               clock = 1'b0;
    logic               reset;
    logic               locked;
    logic               start;
    logic               stop;
    logic [COUNT_W-1:0] budget;
    logic [NUM_REQ-1:0] stall_req;
    logic [NUM_REQ-1:0] stall_ack;
    logic               compute_clock_en_n;
    logic               running;
    logic               done;
    logic               lock_lost;
    logic [COUNT_W-1:0] cycle_count;
    logic [COUNT_W-1:0] stall_cycles;

    compute_clock_gate_ctrl #(
        .NUM_REQ      (NUM_REQ),
        .GATE_LATENCY (GATE_LATENCY),
        .SYNC_STAGES  (SYNC_STAGES),
        .COUNT_W      (COUNT_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .locked             (locked),
        .start              (start),
        .stop               (stop),
        .budget             (budget),
        .stall_req          (stall_req),
        .stall_ack          (stall_ack),
        .compute_clock_en_n (compute_clock_en_n),
        .running            (running),
        .done               (done),
        .lock_lost          (lock_lost),
        .cycle_count        (cycle_count),
        .stall_cycles       (stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                 tag;
        string              name;
        logic               en_n;
        logic [NUM_REQ-1:0] ack;
        logic               run;
        logic               dn;
        logic               ll;
        logic [COUNT_W-1:0] cnt;
        logic [COUNT_W-1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Queue the snapshot expected after the coming rising edge, then move to
    // the next falling edge. Inputs set before the call apply to that edge.
    task automatic nx(input string name, input logic en_n, input logic [NUM_REQ-1:0] ack,
                      input logic run, input logic dn, input logic ll,
                      input logic [COUNT_W-1:0] cnt, input logic [COUNT_W-1:0] sc);
        exp_t e;
        e.tag  = cyc + 1;
        e.name = name;
        e.en_n = en_n;
        e.ack  = ack;
        e.run  = run;
        e.dn   = dn;
        e.ll   = ll;
        e.cnt  = cnt;
`ifdef CLOCK_GATE_STATS_EN
        e.sc   = sc;
`else
        e.sc   = (sc == '0) ? '0 : '0;
`endif
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    // Monitor: compare every queued snapshot on the cycle it targets.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
                e = exp_q.pop_front();
                if (e.tag < cyc) begin
                    check({e.name, ".missed_slot"}, 64'(e.tag), 64'(cyc));
                end else begin
                    check({e.name, ".en_n"},         64'(compute_clock_en_n), 64'(e.en_n));
                    check({e.name, ".stall_ack"},    64'(stall_ack),          64'(e.ack));
                    check({e.name, ".running"},      64'(running),            64'(e.run));
                    check({e.name, ".done"},         64'(done),               64'(e.dn));
                    check({e.name, ".lock_lost"},    64'(lock_lost),          64'(e.ll));
                    check({e.name, ".cycle_count"},  64'(cycle_count),        64'(e.cnt));
                    check({e.name, ".stall_cycles"}, 64'(stall_cycles),       64'(e.sc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        locked    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        budget    = '0;
        stall_req = '0;
        @(negedge clock);

        // Reset state.
        nx("reset", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;

        // Lock bring-up: start while unlocked is ignored.
        start = 1'b1;
        nx("lw_start_ignored", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) nx("lock_wait", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        locked = 1'b1;
        nx("sync_stage1", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        nx("sync_stage2", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        // IDLE is reached on this edge, so a start sampled now is still ignored.
        start = 1'b1;
        nx("early_start_ignored", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        budget = 48'd5;
        nx("start_accept", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, '0, '0);
        start  = 1'b0;
        budget = 48'd3;  // must not affect the latched budget of 5

        // Budget run: exactly 5 enabled cycles.
        for (int i = 1; i <= 4; i++) nx("budget_run", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, COUNT_W'(i), '0);
        nx("budget_done", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 48'd5, '0);
        nx("budget_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 48'd5, '0);

        // Stall handshake with an overlapping second requester.
        budget = '0;
        start  = 1'b1;
        nx("start_unlimited", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, '0, '0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) nx("run", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, COUNT_W'(i), '0);
        stall_req = 4'b0100;
        nx("stall_detect",    1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd4, 48'd0);
        nx("gate_wait",       1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd4, 48'd1);
        nx("gate_to_stalled", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd4, 48'd2);
        nx("ack2",            1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 48'd4, 48'd3);
        stall_req = 4'b0101;
        nx("ack0_late",       1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 48'd4, 48'd4);
        stall_req = 4'b0001;
        nx("ack2_drop",       1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 48'd4, 48'd5);
        nx("hold_gated",      1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 48'd4, 48'd6);
        stall_req = 4'b0000;
        nx("resume",          1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd4, 48'd7);
        nx("resume_count",    1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd5, 48'd7);
        stop = 1'b1;
        nx("stop_done",       1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 48'd6, 48'd7);
        stop      = 1'b0;
        stall_req = 4'b0010;
        nx("idle_no_ack",     1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 48'd6, 48'd7);
        nx("idle_no_ack",     1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 48'd6, 48'd7);
        stall_req = 4'b0000;

        // Priority: budget exhaustion, stop and stall_req on the same edge.
        budget = 48'd3;
        start  = 1'b1;
        nx("start_b3", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd0, 48'd0);
        start  = 1'b0;
        budget = '0;
        nx("b3_run", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd1, 48'd0);
        nx("b3_run", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd2, 48'd0);
        stop      = 1'b1;
        stall_req = 4'b1000;
        nx("prio_done",        1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 48'd3, 48'd0);
        stop = 1'b0;
        nx("prio_single_done", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 48'd3, 48'd0);
        stall_req = 4'b0000;

        // Lock drop mid-stall; start during a run is ignored.
        start = 1'b1;
        nx("start_lockrun", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd0, 48'd0);
        start = 1'b0;
        nx("lockrun", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd1, 48'd0);
        start = 1'b1;
        nx("start_ignored_run", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd2, 48'd0);
        start     = 1'b0;
        stall_req = 4'b0010;
        nx("stall1_detect", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd3, 48'd0);
        nx("stall1_gate",   1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd3, 48'd1);
        nx("stall1_enter",  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 48'd3, 48'd2);
        nx("ack1",          1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 48'd3, 48'd3);
        locked = 1'b0;
        nx("sync_drop1",    1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 48'd3, 48'd4);
        nx("sync_drop2",    1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 48'd3, 48'd5);
        nx("lock_lost",     1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 48'd3, 48'd6);
        nx("lw_no_ack",     1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 48'd3, 48'd6);
        stall_req = 4'b0000;
        locked    = 1'b1;
        for (int i = 0; i < 4; i++) nx("lock_lost_sticky", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 48'd3, 48'd6);

        // Reset clears the sticky flag; then saturation of cycle_count.
        reset = 1'b1;
        nx("reset_after_loss", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) nx("relock", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        start = 1'b1;
        nx("start_sat", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, '0, '0);
        start = 1'b0;
        force dut.cycle_count_q = MAXC - 48'd2;
        #1;
        release dut.cycle_count_q;
        nx("sat_near", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, MAXC - 48'd1, '0);
        nx("sat_max",  1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, MAXC, '0);
        nx("sat_hold", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, MAXC, '0);
        nx("sat_hold", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, MAXC, '0);

        // Reset mid-run forces en_n high on the next edge.
        reset = 1'b1;
        nx("reset_mid_run", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compute_clock_gate_ctrl.md
Name: compute_clock_gate_ctrl

Overview:
Control-clock-domain controller that produces the active-low compute-clock enable consumed by the clock distribution stage. It waits for the MMCM lock indication, then runs the compute clock for a host-set budget of cycles. Stall requesters such as memory or host-access units can freeze the compute clock through a req/ack handshake. It also counts issued compute-clock cycles for the host.

Parameters:
NUM_REQ, 4, number of stall requesters
GATE_LATENCY, 2, control-clock cycles from en_n rising until the gated clock is guaranteed stopped
SYNC_STAGES, 2, synchroniser depth for locked
COUNT_W, 48, width of budget and cycle counters

Ports:
clock  in  1  control clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
locked  in  1  MMCM lock from clock distribution; asynchronous, synchronised internally
start  in  1  single-cycle pulse; begin a run
stop  in  1  single-cycle pulse; abort a run
budget  in  COUNT_W  compute cycles per run; 0 means unlimited; sampled on accepted start
stall_req  in  NUM_REQ  per-requester freeze request, level
stall_ack  out  NUM_REQ  per-requester freeze granted, registered
compute_clock_en_n  out  1  to clock distribution; 0 lets the compute clock toggle
running  out  1  state is RUN, GATE_WAIT or STALLED
done  out  1  one-cycle pulse at run end (budget or stop)
lock_lost  out  1  sticky; lock dropped while not in LOCK_WAIT
cycle_count  out  COUNT_W  compute cycles issued in current/last run
stall_cycles  out  COUNT_W  see Optional Feature

Behaviour:
- All outputs are registered.
- Reset values: en_n=1, stall_ack=0, running=0, done=0, lock_lost=0, cycle_count=0, stall_cycles=0, synchroniser=0, state=LOCK_WAIT.
- locked_s is locked after SYNC_STAGES flops.
- States: LOCK_WAIT, IDLE, RUN, GATE_WAIT, STALLED.
- LOCK_WAIT: en_n=1. Goes to IDLE when locked_s=1.
- IDLE: en_n=1. On start: latch budget, clear cycle_count, go to RUN. en_n is 0 from the next cycle. start is ignored in every other state.
- cycle_count increments on every cycle with registered en_n=0. It saturates at all-ones and never wraps.
- Priority of events in RUN, GATE_WAIT and STALLED: lock loss > stop > budget exhaustion > stall.
  - Lock loss (locked_s=0): go to LOCK_WAIT. en_n=1 and stall_ack=0 next cycle, lock_lost set, no done pulse.
  - stop: go to IDLE. en_n=1, stall_ack=0, done=1 for one cycle.
  - Budget: in RUN, if budget!=0 and en_n=0 and cycle_count+1==budget, go to IDLE, en_n=1, done pulse. Exactly budget cycles have en_n=0.
- RUN with |stall_req=1 (and no higher-priority event): en_n=1 next cycle. Go to GATE_WAIT and load a down-counter with GATE_LATENCY. The cycle that detects the request still counts.
- GATE_WAIT: on the counter reaching 0, go to STALLED. Requests are not acked yet, even if stall_req drops meanwhile.
- STALLED: stall_ack[i] <= stall_req[i] each cycle, so late requesters are acked one cycle after they assert. When stall_req==0, acks clear, en_n=0 next cycle, and the state returns to RUN.
- Requesters must hold req until ack is seen. ack falls one cycle after req falls.
- stall_req while in IDLE or LOCK_WAIT is never acked.
- Reset mid-run forces en_n=1 on the next edge.

Optional Feature:
CLOCK_GATE_STATS_EN
- Defined: stall_cycles clears on accepted start. It increments (saturating) on every cycle in GATE_WAIT or STALLED.
- Undefined: stall_cycles is tied to 0 and no counter is synthesised.

Test Plan:
- Lock bring-up: hold locked=0 for 10 cycles, then assert. Expect IDLE exactly SYNC_STAGES+1 cycles later. start before that is ignored (en_n stays 1).
- Budget run: budget=5, start. Expect exactly 5 cycles of en_n=0 beginning the cycle after start, done pulse as en_n returns to 1, cycle_count=5.
- Stall handshake: budget=0, run, assert stall_req[2] at cycle 3. Expect en_n=1 next cycle, stall_ack[2]=1 GATE_LATENCY+2 cycles after req. Drop req: ack=0 and en_n=0 one cycle later, and cycle_count resumes from 4.
- Overlapping stalls: while STALLED assert req[0] then drop req[2]. Expect ack[0] one cycle later, clock stays gated until req[0] drops; with the macro, stall_cycles equals gated cycles.
- Priority: with budget reached, stall_req and stop all in the same cycle, expect IDLE with a single done pulse and no ack. Lock drop mid-stall: expect LOCK_WAIT, acks 0, lock_lost=1 until reset.
- Unlimited budget with cycle_count preloaded near max by force: expect saturation at all-ones and no wrap.
